// File: rtl/decoder_pkg.sv
// Shared types and helpers for the strobe decoder: FSM state encoding and a
// constant-evaluable clog2 used to size the pulse counter.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_strobe_dec.sv
// Combinational N-to-M one-hot decoder; zero latency, no flow control.
// Indices at or above M decode to all-zero, as does a low enable.
module decoder_strobe_dec #(
    parameter int N = 2,
    parameter int M = 3
) (
    input  logic [N-1:0] sel,
    input  logic         en,
    output logic [M-1:0] dec
);

    always_comb begin
        dec = '0;
        for (int i = 0; i < M; i++) begin
            dec[i] = en && (sel == N'(i));
        end
    end

endmodule

// File: rtl/decoder_strobe.sv
// Handshaked one-hot strobe generator: accept at edge T drives out[addr] from T+1
// for PULSE_W enabled cycles; req_ready is low while a sequence runs or abort is set.
module decoder_strobe
    import decoder_pkg::*;
#(
    parameter int N       = 2,
    parameter int M       = 3,
    parameter int PULSE_W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_addr,
    input  logic         req_scan,
    input  logic         ena,
    input  logic         abort,
    output logic [M-1:0] out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    if (M < 1 || M > (1 << N)) begin : g_bad_m
        $error("decoder_strobe: M must satisfy 1 <= M <= 2**N");
    end
    if (PULSE_W < 1) begin : g_bad_pw
        $error("decoder_strobe: PULSE_W must be >= 1");
    end

    localparam int            CW    = clog2(PULSE_W + 1);
    localparam logic [CW-1:0] PW    = CW'(PULSE_W);
    localparam logic [N:0]    M_LIM = (N + 1)'(M);
    localparam logic [N-1:0]  LAST  = N'(M - 1);

    state_t        state, state_d;
    logic [N-1:0]  idx, idx_d;
    logic          scan, scan_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic          done_d, err_d;
    logic          accept, addr_ok, act;
    logic [M-1:0]  dec_out;

    assign req_ready = rst_n && (state == IDLE) && !abort;
    assign accept    = req_valid && req_ready;
    assign addr_ok   = {1'b0, req_addr} < M_LIM;
    assign busy      = (state != IDLE);
    assign cnt_inc   = cnt + CW'(1);
    // A pulse cycle is consumed only when the strobe was actually visible.
    assign act       = |out;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        scan_d  = scan;
        cnt_d   = cnt;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (addr_ok) begin
                            state_d = HOLD;
                            idx_d   = req_addr;
                            scan_d  = req_scan;
                            cnt_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (act) begin
                        if (cnt_inc == PW) begin
                            cnt_d = '0;
                            if (!scan || idx == LAST) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                idx_d = idx + N'(1);
                            end
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Decoding the next-state index lets the registered strobe appear one cycle after accept.
    decoder_strobe_dec #(
        .N (N),
        .M (M)
    ) u_dec (
        .sel (idx_d),
        .en  ((state_d == HOLD) && ena),
        .dec (dec_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            scan  <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            scan  <= scan_d;
            cnt   <= cnt_d;
            out   <= dec_out;
            done  <= done_d;
            err   <= err_d;
        end
    end

endmodule
